// File: rtl/icb_xfer_master.sv
// Word-by-word memory copy engine on an ICB master port: each word is read
// from the source, held in a one-word buffer, then written to the destination.
module icb_xfer_master #(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             o_icb_cmd_valid,
  input  logic             o_icb_cmd_ready,
  output logic [31:0]      o_icb_cmd_addr,
  output logic             o_icb_cmd_read,
  output logic [31:0]      o_icb_cmd_wdata,
  output logic [3:0]       o_icb_cmd_wmask,
  input  logic             o_icb_rsp_valid,
  output logic             o_icb_rsp_ready,
  input  logic             o_icb_rsp_err,
  input  logic [31:0]      o_icb_rsp_rdata
);

  // state  | meaning
  // IDLE   | waiting for start
  // RD_CMD | read command presented at the source address
  // RD_RSP | waiting for read data
  // WR_CMD | write command presented at the destination address
  // WR_RSP | waiting for write acknowledge
  // FIN    | one-cycle done pulse
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_CMD = 3'd1,
    RD_RSP = 3'd2,
    WR_CMD = 3'd3,
    WR_RSP = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t           state, state_nx;
  logic [31:0]      src_q;
  logic [31:0]      dst_q;
  logic [LEN_W-1:0] cnt_q;
  logic [31:0]      buf_q;
  logic             err_q;

  logic cmd_hs;
  logic rsp_ok;
  logic rsp_bad;

  assign cmd_hs  = o_icb_cmd_valid & o_icb_cmd_ready;
  assign rsp_ok  = o_icb_rsp_valid & ~o_icb_rsp_err;
  assign rsp_bad = o_icb_rsp_valid & o_icb_rsp_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nx = (len != '0) ? RD_CMD : FIN;
        end
      end
      RD_CMD: begin
        if (cmd_hs) state_nx = RD_RSP;
      end
      RD_RSP: begin
        if (rsp_bad)     state_nx = FIN;
        else if (rsp_ok) state_nx = WR_CMD;
      end
      WR_CMD: begin
        if (cmd_hs) state_nx = WR_RSP;
      end
      WR_RSP: begin
        if (rsp_bad) begin
          state_nx = FIN;
        end else if (rsp_ok) begin
          // count is decremented on this same edge, so 1 means last word
          state_nx = (cnt_q == LEN_W'(1)) ? FIN : RD_CMD;
        end
      end
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
      buf_q <= '0;
      err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            src_q <= src_addr;
            dst_q <= dst_addr;
            cnt_q <= len;
            err_q <= 1'b0;
          end
        end
        RD_RSP: begin
          if (rsp_bad)     err_q <= 1'b1;
          else if (rsp_ok) buf_q <= o_icb_rsp_rdata;
        end
        WR_RSP: begin
          if (rsp_bad) begin
            err_q <= 1'b1;
          end else if (rsp_ok) begin
            src_q <= src_q + 32'd4;
            dst_q <= dst_q + 32'd4;
            cnt_q <= cnt_q - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Command fields decode straight from state and registers, so they cannot
  // move while a command waits for ready.
  always_comb begin
    o_icb_cmd_valid = 1'b0;
    o_icb_cmd_addr  = '0;
    o_icb_cmd_read  = 1'b0;
    o_icb_cmd_wmask = 4'h0;
    o_icb_rsp_ready = 1'b0;
    case (state)
      RD_CMD: begin
        o_icb_cmd_valid = 1'b1;
        o_icb_cmd_addr  = src_q;
        o_icb_cmd_read  = 1'b1;
      end
      WR_CMD: begin
        o_icb_cmd_valid = 1'b1;
        o_icb_cmd_addr  = dst_q;
        o_icb_cmd_wmask = 4'hF;
      end
      RD_RSP, WR_RSP: o_icb_rsp_ready = 1'b1;
      default: ;
    endcase
  end

  assign o_icb_cmd_wdata = buf_q;
  assign busy            = (state != IDLE);
  assign done            = (state == FIN);
  assign err             = err_q;

endmodule

// File: tb/tb_icb_xfer_master.sv
// Directed bench for icb_xfer_master: a negedge-driven ICB slave model returns
// rdata = addr ^ 32'h5A5A_5A5A one cycle after each accepted command.
module tb_icb_xfer_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] src_addr;
  logic [31:0] dst_addr;
  logic [15:0] len;
  logic        busy, done, err;
  logic        o_icb_cmd_valid;
  logic        o_icb_cmd_ready = 1'b0;
  logic [31:0] o_icb_cmd_addr;
  logic        o_icb_cmd_read;
  logic [31:0] o_icb_cmd_wdata;
  logic [3:0]  o_icb_cmd_wmask;
  logic        o_icb_rsp_valid = 1'b0;
  logic        o_icb_rsp_ready;
  logic        o_icb_rsp_err = 1'b0;
  logic [31:0] o_icb_rsp_rdata = 32'h0;

  icb_xfer_master #(.LEN_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
    .busy(busy), .done(done), .err(err),
    .o_icb_cmd_valid(o_icb_cmd_valid), .o_icb_cmd_ready(o_icb_cmd_ready),
    .o_icb_cmd_addr(o_icb_cmd_addr), .o_icb_cmd_read(o_icb_cmd_read),
    .o_icb_cmd_wdata(o_icb_cmd_wdata), .o_icb_cmd_wmask(o_icb_cmd_wmask),
    .o_icb_rsp_valid(o_icb_rsp_valid), .o_icb_rsp_ready(o_icb_rsp_ready),
    .o_icb_rsp_err(o_icb_rsp_err), .o_icb_rsp_rdata(o_icb_rsp_rdata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // slave configuration (written by the main sequence only)
  int stall_rd  = 0;
  int stall_len = 0;
  int err_rd    = 0;

  // slave-owned state and logs
  int          rd_cnt    = 0;
  int          stall_n   = 0;
  int          done_cnt  = 0;
  int          valid_cnt = 0;
  logic        pend      = 1'b0;
  logic        pend_err  = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  logic [31:0] log_addr[$];
  logic        log_rd[$];
  logic [31:0] log_wdata[$];
  logic [3:0]  log_wmask[$];

  localparam logic [31:0] E1_ADDR [6] = '{32'h1014_0000, 32'h1018_0000, 32'h1014_0004,
                                          32'h1018_0004, 32'h1014_0008, 32'h1018_0008};
  localparam logic [31:0] E1_WDATA[3] = '{32'h4A4E_5A5A, 32'h4A4E_5A5E, 32'h4A4E_5A52};

  always @(negedge clk) begin
    if (!rst_n) begin
      o_icb_cmd_ready = 1'b0;
      o_icb_rsp_valid = 1'b0;
      o_icb_rsp_err   = 1'b0;
      pend            = 1'b0;
      stall_n         = 0;
    end else begin
      if (done === 1'b1) done_cnt++;
      if (o_icb_cmd_valid === 1'b1) valid_cnt++;
      o_icb_rsp_valid = 1'b0;
      o_icb_rsp_err   = 1'b0;
      if (pend) begin
        o_icb_rsp_valid = 1'b1;
        o_icb_rsp_rdata = pend_addr ^ 32'h5A5A_5A5A;
        o_icb_rsp_err   = pend_err;
        pend            = 1'b0;
      end
      if (o_icb_cmd_valid && o_icb_cmd_read && (rd_cnt + 1 == stall_rd) && stall_n < stall_len) begin
        o_icb_cmd_ready = 1'b0;
        stall_n++;
      end else begin
        o_icb_cmd_ready = 1'b1;
      end
      if (o_icb_cmd_valid && o_icb_cmd_ready) begin
        log_addr.push_back(o_icb_cmd_addr);
        log_rd.push_back(o_icb_cmd_read);
        log_wdata.push_back(o_icb_cmd_wdata);
        log_wmask.push_back(o_icb_cmd_wmask);
        pend      = 1'b1;
        pend_addr = o_icb_cmd_addr;
        pend_err  = 1'b0;
        stall_n   = 0;
        if (o_icb_cmd_read) begin
          rd_cnt++;
          if (rd_cnt == err_rd) pend_err = 1'b1;
        end
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] lg_addr(input int i);
    return (i < log_addr.size()) ? log_addr[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] lg_rd(input int i);
    return (i < log_rd.size()) ? 32'(log_rd[i]) : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] lg_wdata(input int i);
    return (i < log_wdata.size()) ? log_wdata[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [31:0] lg_wmask(input int i);
    return (i < log_wmask.size()) ? 32'(log_wmask[i]) : 32'hDEAD_BEEF;
  endfunction

  // called at a negedge; returns at the following negedge with start low
  task automatic start_xfer(input logic [31:0] s, input logic [31:0] d, input logic [15:0] n);
    start = 1'b1; src_addr = s; dst_addr = d; len = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (done !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(done), 32'h1);
  endtask

  task automatic chk_all_low(input string tag);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_done"},  32'(done), 0);
    chk({tag, "_err"},   32'(err), 0);
    chk({tag, "_valid"}, 32'(o_icb_cmd_valid), 0);
    chk({tag, "_rrdy"},  32'(o_icb_rsp_ready), 0);
    chk({tag, "_read"},  32'(o_icb_cmd_read), 0);
    chk({tag, "_wmask"}, 32'(o_icb_cmd_wmask), 0);
    chk({tag, "_addr"},  o_icb_cmd_addr, 0);
    chk({tag, "_wdata"}, o_icb_cmd_wdata, 0);
  endtask

  initial begin
    int base;
    int d0;
    int v0;
    int n;
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    repeat (2) @(negedge clk);
    chk_all_low("rst");
    rst_n = 1'b1;
    @(negedge clk);

    // basic 3-word copy
    base = log_addr.size(); d0 = done_cnt;
    start_xfer(32'h1014_0000, 32'h1018_0000, 16'd3);
    chk("t1_valid_first", 32'(o_icb_cmd_valid), 1);
    chk("t1_read_first",  32'(o_icb_cmd_read), 1);
    chk("t1_addr_first",  o_icb_cmd_addr, 32'h1014_0000);
    chk("t1_busy",        32'(busy), 1);
    wait_done("t1_done");
    chk("t1_err", 32'(err), 0);
    @(negedge clk);
    chk("t1_idle_busy", 32'(busy), 0);
    chk("t1_ncmd", 32'(log_addr.size() - base), 6);
    chk("t1_ndone", 32'(done_cnt - d0), 1);
    for (int i = 0; i < 6; i++) begin
      chk("t1_log_addr", lg_addr(base + i), E1_ADDR[i]);
      chk("t1_log_read", lg_rd(base + i), ((i % 2) == 0) ? 32'h1 : 32'h0);
      chk("t1_log_wmask", lg_wmask(base + i), ((i % 2) == 0) ? 32'h0 : 32'hF);
      if ((i % 2) == 1) chk("t1_log_wdata", lg_wdata(base + i), E1_WDATA[i / 2]);
    end

    // first read stalled by cmd_ready low for 5 cycles
    @(posedge clk); #1;
    stall_rd = rd_cnt + 1; stall_len = 5;
    @(negedge clk);
    base = log_addr.size(); d0 = done_cnt;
    start_xfer(32'h1014_0100, 32'h1018_0100, 16'd1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_valid", 32'(o_icb_cmd_valid), 1);
      chk("t2_stall_addr",  o_icb_cmd_addr, 32'h1014_0100);
      chk("t2_stall_read",  32'(o_icb_cmd_read), 1);
      @(negedge clk);
    end
    wait_done("t2_done");
    @(negedge clk);
    chk("t2_ncmd",  32'(log_addr.size() - base), 2);
    chk("t2_rd0",   lg_rd(base), 1);
    chk("t2_rd1",   lg_rd(base + 1), 0);
    chk("t2_wdata", lg_wdata(base + 1), 32'h4A4E_5B5A);
    chk("t2_ndone", 32'(done_cnt - d0), 1);

    // error on the second read of a 4-word transfer
    @(posedge clk); #1;
    stall_rd = 0; err_rd = rd_cnt + 2;
    @(negedge clk);
    base = log_addr.size(); d0 = done_cnt;
    start_xfer(32'h2000_0000, 32'h3000_0000, 16'd4);
    wait_done("t3_done");
    chk("t3_err_at_done", 32'(err), 1);
    repeat (5) @(negedge clk);
    chk("t3_err_held", 32'(err), 1);
    chk("t3_busy", 32'(busy), 0);
    chk("t3_ncmd", 32'(log_addr.size() - base), 3);
    chk("t3_a0", lg_addr(base), 32'h2000_0000);
    chk("t3_a1", lg_addr(base + 1), 32'h3000_0000);
    chk("t3_r1", lg_rd(base + 1), 0);
    chk("t3_w1", lg_wdata(base + 1), 32'h7A5A_5A5A);
    chk("t3_a2", lg_addr(base + 2), 32'h2000_0004);
    chk("t3_ndone", 32'(done_cnt - d0), 1);

    // zero length: done one edge after the start edge, no traffic
    @(posedge clk); #1;
    err_rd = 0;
    @(negedge clk);
    v0 = valid_cnt; d0 = done_cnt;
    start_xfer(32'h1111_0000, 32'h2222_0000, 16'd0);
    chk("t4_done", 32'(done), 1);
    chk("t4_err_cleared", 32'(err), 0);
    chk("t4_valid", 32'(o_icb_cmd_valid), 0);
    @(negedge clk);
    chk("t4_done_off", 32'(done), 0);
    chk("t4_busy_off", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("t4_no_valid", 32'(valid_cnt - v0), 0);
    chk("t4_ndone", 32'(done_cnt - d0), 1);

    // address wrap
    base = log_addr.size();
    start_xfer(32'hFFFF_FFFC, 32'h4000_0000, 16'd2);
    wait_done("t5_done");
    @(negedge clk);
    chk("t5_ncmd", 32'(log_addr.size() - base), 4);
    chk("t5_a0", lg_addr(base), 32'hFFFF_FFFC);
    chk("t5_w0", lg_wdata(base + 1), 32'hA5A5_A5A6);
    chk("t5_a2_wrap", lg_addr(base + 2), 32'h0000_0000);
    chk("t5_a3", lg_addr(base + 3), 32'h4000_0004);
    chk("t5_w1", lg_wdata(base + 3), 32'h5A5A_5A5A);

    // reset during WR_CMD
    start_xfer(32'h8000_0000, 32'h9000_0000, 16'd6);
    n = 0;
    while (!(o_icb_cmd_valid === 1'b1 && o_icb_cmd_read === 1'b0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reached_wr", 32'(o_icb_cmd_valid & ~o_icb_cmd_read), 1);
    #1 rst_n = 1'b0;
    #1 chk_all_low("t6_rst");
    @(negedge clk);
    chk_all_low("t6_rst2");
    rst_n = 1'b1;
    d0 = done_cnt;
    repeat (6) @(negedge clk);
    chk("t6_no_done", 32'(done_cnt - d0), 0);
    chk("t6_idle", 32'(busy), 0);

    // start held high while busy, inputs changed mid-transfer
    @(posedge clk); #1;
    stall_rd = rd_cnt + 1; stall_len = 6;
    @(negedge clk);
    base = log_addr.size(); d0 = done_cnt;
    start = 1'b1; src_addr = 32'h5000_0000; dst_addr = 32'h6000_0000; len = 16'd1;
    @(negedge clk);
    src_addr = 32'h7000_0000; dst_addr = 32'h7100_0000; len = 16'd5;
    for (int i = 0; i < 3; i++) begin
      chk("t7_addr_held", o_icb_cmd_addr, 32'h5000_0000);
      @(negedge clk);
    end
    start = 1'b0;
    wait_done("t7_done");
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("t7_ncmd", 32'(log_addr.size() - base), 2);
    chk("t7_a0", lg_addr(base), 32'h5000_0000);
    chk("t7_a1", lg_addr(base + 1), 32'h6000_0000);
    chk("t7_ndone", 32'(done_cnt - d0), 1);
    chk("t7_busy", 32'(busy), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
